// File: rtl/giraffe_capture_fsm.sv
// giraffe_capture_fsm
//   Sequences an external ADC: reset pulse, calibration run, sample capture
//   into an on-chip memory, and a byte-serial dump of that memory over a UART
//   write port.
//
// Ports
//   clk, nrst, pll_locked         clock, async active-low reset, clock-valid
//   cmd[CMDLENGTH], cmd_vld       command word (1 CALIB, 2 SAMPLE, 3 DUMP,
//                                 4 ABORT) and its one-cycle strobe
//   sw_nowa[9]                    NOWA setting, latched when a run starts
//   adc_rstn, adc_calib_ena,
//   adc_ena, adc_nowa[9]          ADC control outputs
//   adc_ack[NUM_CH], adc_dout     ADC acknowledge lines and sample data
//   uart_wdata[8], uart_wreq,
//   uart_rdy                      byte stream out (transfer on wreq & rdy)
//   state[4]                      current FSM state
//   cnt_received[32]              samples held in memory
//   capture_done, err             capture filled memory / watchdog tripped
//
// Build option
//   GIRAFFE_ACK_TIMEOUT_EN        adds the acknowledge watchdog and the ERROR
//                                 state; without it err is tied low.
module giraffe_capture_fsm #(
  parameter int NUM_BIT        = 6,
  parameter int NUM_CH         = 2,
  parameter int DEPTH          = 1024,
  parameter int NUM_CALIB      = 1000,
  parameter int RST_CYCLES     = 16,
  parameter int CMDLENGTH      = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 pll_locked,
  input  logic [CMDLENGTH-1:0] cmd,
  input  logic                 cmd_vld,
  input  logic [8:0]           sw_nowa,
  output logic                 adc_rstn,
  output logic                 adc_calib_ena,
  output logic                 adc_ena,
  output logic [8:0]           adc_nowa,
  input  logic [NUM_CH-1:0]    adc_ack,
  input  logic [NUM_BIT-1:0]   adc_dout,
  output logic [7:0]           uart_wdata,
  output logic                 uart_wreq,
  input  logic                 uart_rdy,
  output logic [3:0]           state,
  output logic [31:0]          cnt_received,
  output logic                 capture_done,
  output logic                 err
);

  localparam int NBYTES = (NUM_BIT + 7) / 8;
  localparam int PW     = NBYTES * 8;
  localparam int BIW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_ARST = 4'd1, S_CALIB = 4'd2,
    S_SAMPLE = 4'd3, S_DUMP = 4'd4, S_ERROR = 4'd5
  } st_t;

  typedef enum logic [1:0] {D_RD, D_WAIT, D_SEND} dph_t;

  st_t              cur_st, nxt_st;
  dph_t             dphase;
  logic             mode_calib;
  logic [31:0]      rst_cnt, calib_cnt, rd_idx;
  logic [BIW-1:0]   byte_idx;
  logic             ack_p0, ack_p1, ack_p2, ack_rise;
  logic             wd_timeout;
  logic [NUM_BIT-1:0] mem [DEPTH];
  logic [NUM_BIT-1:0] rd_data;

  // Sample is zero-extended to whole bytes; idx 0 is the least significant byte.
  function automatic logic [7:0] get_byte(input logic [NUM_BIT-1:0] s,
                                          input logic [BIW-1:0] idx);
    logic [PW-1:0] ext;
    ext = PW'(s);
    return 8'(ext >> (8 * idx));
  endfunction

  logic cmd_calib, cmd_sample, cmd_dump, cmd_abort;
  assign cmd_calib  = pll_locked && cmd_vld && (cmd == CMDLENGTH'(1));
  assign cmd_sample = pll_locked && cmd_vld && (cmd == CMDLENGTH'(2));
  assign cmd_dump   = pll_locked && cmd_vld && (cmd == CMDLENGTH'(3));
  assign cmd_abort  = pll_locked && cmd_vld && (cmd == CMDLENGTH'(4));

  // ---- ack stage p0/p1: synchroniser, p2: edge reference ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_p0 <= 1'b0;
      ack_p1 <= 1'b0;
      ack_p2 <= 1'b0;
    end else if (!pll_locked) begin
      ack_p0 <= 1'b0;
      ack_p1 <= 1'b0;
      ack_p2 <= 1'b0;
    end else begin
      ack_p0 <= |adc_ack;
      ack_p1 <= ack_p0;
      ack_p2 <= ack_p1;
    end
  end
  assign ack_rise = ack_p1 & ~ack_p2;

  logic arst_done, calib_last, wr_en, samp_last, rd_en, dump_xfer, dump_last;
  assign arst_done  = (cur_st == S_ARST) && (rst_cnt == 32'(RST_CYCLES - 1));
  assign calib_last = (cur_st == S_CALIB) && ack_rise && (calib_cnt == 32'(NUM_CALIB - 1));
  // ABORT wins over a coincident acknowledge: that sample is dropped.
  assign wr_en      = pll_locked && (cur_st == S_SAMPLE) && ack_rise && !cmd_abort;
  assign samp_last  = wr_en && (cnt_received == 32'(DEPTH - 1));
  assign rd_en      = (cur_st == S_DUMP) && (dphase == D_RD);
  assign dump_xfer  = (cur_st == S_DUMP) && (dphase == D_SEND) && uart_wreq && uart_rdy;
  assign dump_last  = dump_xfer && (byte_idx == '0) && (rd_idx == cnt_received - 32'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            cur_st <= S_IDLE;
    else if (!pll_locked) cur_st <= S_IDLE;
    else                  cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    if (cmd_abort) begin
      nxt_st = S_IDLE;
    end else begin
      case (cur_st)
        S_IDLE:   if (cmd_calib || cmd_sample) nxt_st = S_ARST;
                  else if (cmd_dump)           nxt_st = S_DUMP;
        S_ARST:   if (arst_done) nxt_st = mode_calib ? S_CALIB : S_SAMPLE;
        S_CALIB:  if (calib_last)      nxt_st = S_IDLE;
                  else if (wd_timeout) nxt_st = S_ERROR;
        S_SAMPLE: if (samp_last)       nxt_st = S_IDLE;
                  else if (wd_timeout) nxt_st = S_ERROR;
        S_DUMP:   if ((cnt_received == 32'd0) || dump_last) nxt_st = S_IDLE;
        S_ERROR:  nxt_st = S_ERROR;
        default:  nxt_st = S_IDLE;
      endcase
    end
  end

  always_comb begin
    adc_rstn      = (cur_st != S_ARST);
    adc_ena       = (cur_st == S_CALIB) || (cur_st == S_SAMPLE);
    adc_calib_ena = (cur_st == S_CALIB);
  end
  assign state = cur_st;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      adc_nowa     <= '0;
      mode_calib   <= 1'b0;
      cnt_received <= '0;
      capture_done <= 1'b0;
      rst_cnt      <= '0;
      calib_cnt    <= '0;
      rd_idx       <= '0;
      byte_idx     <= BIW'(NBYTES - 1);
      dphase       <= D_RD;
      uart_wreq    <= 1'b0;
      uart_wdata   <= '0;
    end else if (!pll_locked) begin
      adc_nowa     <= '0;
      mode_calib   <= 1'b0;
      cnt_received <= '0;
      capture_done <= 1'b0;
      rst_cnt      <= '0;
      calib_cnt    <= '0;
      rd_idx       <= '0;
      byte_idx     <= BIW'(NBYTES - 1);
      dphase       <= D_RD;
      uart_wreq    <= 1'b0;
      uart_wdata   <= '0;
    end else begin
      if ((cur_st == S_IDLE) && (cmd_calib || cmd_sample)) begin
        adc_nowa     <= sw_nowa;
        mode_calib   <= cmd_calib;
        cnt_received <= '0;
        capture_done <= 1'b0;
      end else if (wr_en) begin
        cnt_received <= cnt_received + 32'd1;
        if (samp_last) capture_done <= 1'b1;
      end
      rst_cnt   <= (cur_st == S_ARST) ? rst_cnt + 32'd1 : 32'd0;
      calib_cnt <= (cur_st == S_CALIB) ? calib_cnt + 32'(ack_rise) : 32'd0;

      // Dump walk: read address, wait for RAM data, then hand out bytes MSB
      // first. wreq drops for one cycle after every accepted byte.
      if ((cur_st != S_DUMP) || cmd_abort) begin
        rd_idx    <= '0;
        byte_idx  <= BIW'(NBYTES - 1);
        dphase    <= D_RD;
        uart_wreq <= 1'b0;
      end else begin
        case (dphase)
          D_RD:   dphase <= D_WAIT;
          D_WAIT: begin
            dphase   <= D_SEND;
            byte_idx <= BIW'(NBYTES - 1);
          end
          D_SEND: begin
            if (!uart_wreq) begin
              uart_wreq  <= 1'b1;
              uart_wdata <= get_byte(rd_data, byte_idx);
            end else if (uart_rdy) begin
              uart_wreq <= 1'b0;
              if (byte_idx == '0) begin
                rd_idx <= rd_idx + 32'd1;
                dphase <= D_RD;
              end else begin
                byte_idx <= byte_idx - 1'b1;
              end
            end
          end
          default: dphase <= D_RD;
        endcase
      end
    end
  end

  // Sample memory: no reset so it maps onto block RAM; registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_received[AW-1:0]] <= adc_dout;
    if (rd_en) rd_data <= mem[rd_idx[AW-1:0]];
  end

`ifdef GIRAFFE_ACK_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_armed;
  assign wd_armed = ((cur_st == S_CALIB) || (cur_st == S_SAMPLE)) && !ack_rise;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            wd_cnt <= '0;
    else if (!pll_locked) wd_cnt <= '0;
    else if (wd_armed)    wd_cnt <= wd_cnt + 32'd1;
    else                  wd_cnt <= '0;
  end

  assign wd_timeout = wd_armed && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign err        = (cur_st == S_ERROR);
`else
  // Keeps TIMEOUT_CYCLES referenced in builds without the watchdog.
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wd_timeout = 1'b0;
  assign err        = 1'b0;
`endif

endmodule
